// File: rtl/demux_dispatch.sv
// One-deep dispatch stage: holds a single word and offers it to the channel named
// by its destination index; words stuck longer than TMO cycles are dropped and counted.
module demux_dispatch #(
    parameter int S   = 3,
    parameter int T   = 1,
    parameter int TMO = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [T-1:0]          in_data,
    input  logic [S-1:0]          in_dest,
    input  logic [(2**S)-1:0]     out_ready,
    output logic [(2**S)-1:0]     out_valid,
    output logic [(2**S)*T-1:0]   out,
    output logic [S-1:0]          ctrl,
    output logic                  drop,
    output logic [7:0]            drop_cnt
);

    localparam int N  = 2**S;
    localparam int WW = (TMO > 1) ? $clog2(TMO) : 1;
    localparam logic [WW-1:0] WAIT_LAST = (TMO > 0) ? WW'(TMO - 1) : '0;

    typedef enum logic {EMPTY, HOLD} state_t;

    state_t          state_reg, state_next;
    logic [T-1:0]    data_reg, data_next;
    logic [S-1:0]    dest_reg, dest_next;
    logic [WW-1:0]   wait_reg, wait_next;
    logic            drop_reg, drop_next;
    logic [7:0]      drop_cnt_reg, drop_cnt_next;
    logic            xfer;
    logic            timeout;
    logic            acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= EMPTY;
            data_reg     <= '0;
            dest_reg     <= '0;
            wait_reg     <= '0;
            drop_reg     <= 1'b0;
            drop_cnt_reg <= 8'd0;
        end else begin
            state_reg    <= state_next;
            data_reg     <= data_next;
            dest_reg     <= dest_next;
            wait_reg     <= wait_next;
            drop_reg     <= drop_next;
            drop_cnt_reg <= drop_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        data_next     = data_reg;
        dest_next     = dest_reg;
        wait_next     = wait_reg;
        drop_next     = 1'b0;
        drop_cnt_next = drop_cnt_reg;

        xfer    = (state_reg == HOLD) && out_ready[dest_reg];
        // A delivery in the last allowed cycle wins over the timeout.
        timeout = (TMO > 0) && (state_reg == HOLD) && !xfer && (wait_reg == WAIT_LAST);
        in_ready = !rst && ((state_reg == EMPTY) || xfer);
        acc      = in_valid && in_ready;

        if (acc) begin
            state_next = HOLD;
            data_next  = in_data;
            dest_next  = in_dest;
            wait_next  = '0;
        end else if (xfer) begin
            state_next = EMPTY;
            wait_next  = '0;
        end else if (timeout) begin
            state_next = EMPTY;
            wait_next  = '0;
            drop_next  = 1'b1;
            if (drop_cnt_reg != 8'hFF) begin
                drop_cnt_next = drop_cnt_reg + 8'd1;
            end
        end else if (state_reg == HOLD) begin
            wait_next = wait_reg + 1'b1;
        end
    end

    // Outputs come only from registers, so nothing on in_* reaches out* in the same cycle.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_ch
            assign out_valid[gi]     = (state_reg == HOLD) && (dest_reg == S'(gi));
            assign out[gi*T +: T]    = out_valid[gi] ? data_reg : '0;
        end
    endgenerate

    assign ctrl     = dest_reg;
    assign drop     = drop_reg;
    assign drop_cnt = drop_cnt_reg;

endmodule
